// File: rtl/alu_serial_rx_if.sv
// Serial ALU command receiver bus: serial input line plus decoded
// packet results and status flags.
interface alu_serial_rx_if;
   logic        sin;
   logic        pkt_valid;
   logic [31:0] a_out;
   logic [31:0] b_out;
   logic [2:0]  op_out;
   logic        err_data;
   logic        err_crc;
   logic        err_op;
   logic        err_frame;
   logic        busy;

   modport master (
      output sin,
      input  pkt_valid, a_out, b_out, op_out,
      input  err_data, err_crc, err_op, err_frame, busy
   );

   modport slave (
      input  sin,
      output pkt_valid, a_out, b_out, op_out,
      output err_data, err_crc, err_op, err_frame, busy
   );
endinterface

// File: rtl/alu_serial_rx.sv
// Serial ALU packet receiver: 8 DATA frames carrying {B,A} followed by
// one CMD frame carrying op and a CRC4 over {B,A,1,op}.
module alu_serial_rx (
   input logic            clk,
   input logic            rst_n,
   alu_serial_rx_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TYPE,
      S_DATA,
      S_STOP,
      S_WAIT
   } state_e;

   state_e      state_q, state_d;
   logic        is_cmd_q, is_cmd_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [3:0]  data_cnt_q, data_cnt_d;
   logic [63:0] sr_q, sr_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [3:0]  crc_q, crc_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [2:0]  op_q, op_d;
   logic        pkt_valid_q, pkt_valid_d;
   logic        err_data_q, err_data_d;
   logic        err_crc_q, err_crc_d;
   logic        err_op_q, err_op_d;
   logic        err_frame_q, err_frame_d;
   logic        busy_q, busy_d;

   logic        crc_in;
   logic        crc_fb;
   logic [3:0]  crc_step;

   // CMD bit7 is replaced by the constant 1 the CRC is defined over
   assign crc_in   = (is_cmd_q && bit_cnt_q == 3'd7) ? 1'b1 : bus.sin;
   assign crc_fb   = crc_q[3] ^ crc_in;
   assign crc_step = {crc_q[2:0], 1'b0} ^ (crc_fb ? 4'b0011 : 4'b0000);

   always_comb begin
      state_d     = state_q;
      is_cmd_d    = is_cmd_q;
      bit_cnt_d   = bit_cnt_q;
      data_cnt_d  = data_cnt_q;
      sr_d        = sr_q;
      cmd_d       = cmd_q;
      crc_d       = crc_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      busy_d      = busy_q;
      pkt_valid_d = 1'b0;
      err_data_d  = 1'b0;
      err_crc_d   = 1'b0;
      err_op_d    = 1'b0;
      err_frame_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!bus.sin) begin
               state_d = S_TYPE;
               busy_d  = 1'b1;
            end
         end
         S_TYPE: begin
            is_cmd_d  = bus.sin;
            bit_cnt_d = 3'd7;
            state_d   = S_DATA;
         end
         S_DATA: begin
            if (is_cmd_q) begin
               cmd_d = {cmd_q[6:0], bus.sin};
               if (bit_cnt_q >= 3'd4) crc_d = crc_step;
            end else begin
               sr_d  = {sr_q[62:0], bus.sin};
               crc_d = crc_step;
            end
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) state_d = S_STOP;
         end
         S_STOP: begin
            if (!bus.sin) begin
               err_frame_d = 1'b1;
               busy_d      = 1'b0;
               data_cnt_d  = 4'd0;
               sr_d        = 64'd0;
               crc_d       = 4'd0;
               state_d     = S_WAIT;
            end else if (!is_cmd_q) begin
               if (data_cnt_q != 4'd9) data_cnt_d = data_cnt_q + 4'd1;
               state_d = S_IDLE;
            end else begin
               pkt_valid_d = 1'b1;
               busy_d      = 1'b0;
               if (data_cnt_q != 4'd8) begin
                  err_data_d = 1'b1;
               end else if (crc_q != cmd_q[3:0]) begin
                  err_crc_d = 1'b1;
               end else if (cmd_q[5]) begin
                  err_op_d = 1'b1;
               end else begin
                  a_d  = sr_q[31:0];
                  b_d  = sr_q[63:32];
                  op_d = cmd_q[6:4];
               end
               data_cnt_d = 4'd0;
               sr_d       = 64'd0;
               crc_d      = 4'd0;
               state_d    = S_IDLE;
            end
         end
         // after a framing error the line must return high first
         S_WAIT: begin
            if (bus.sin) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         is_cmd_q    <= 1'b0;
         bit_cnt_q   <= 3'd0;
         data_cnt_q  <= 4'd0;
         sr_q        <= 64'd0;
         cmd_q       <= 8'd0;
         crc_q       <= 4'd0;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         op_q        <= 3'd0;
         pkt_valid_q <= 1'b0;
         err_data_q  <= 1'b0;
         err_crc_q   <= 1'b0;
         err_op_q    <= 1'b0;
         err_frame_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_cmd_q    <= is_cmd_d;
         bit_cnt_q   <= bit_cnt_d;
         data_cnt_q  <= data_cnt_d;
         sr_q        <= sr_d;
         cmd_q       <= cmd_d;
         crc_q       <= crc_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         pkt_valid_q <= pkt_valid_d;
         err_data_q  <= err_data_d;
         err_crc_q   <= err_crc_d;
         err_op_q    <= err_op_d;
         err_frame_q <= err_frame_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.pkt_valid = pkt_valid_q;
   assign bus.a_out     = a_q;
   assign bus.b_out     = b_q;
   assign bus.op_out    = op_q;
   assign bus.err_data  = err_data_q;
   assign bus.err_crc   = err_crc_q;
   assign bus.err_op    = err_op_q;
   assign bus.err_frame = err_frame_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed bench for alu_serial_rx: good packets, each error class,
// framing error, mid-packet reset and zero-gap back-to-back packets.
module tb_alu_serial_rx;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vecs = 0;
   int   errs = 0;
   int   cyc = 0;

   int          pv_cnt = 0;
   int          ef_cnt = 0;
   int          pv_last_cyc = 0;
   int          pv_prev_cyc = 0;
   logic [31:0] pv_last_a, pv_prev_a;
   logic [31:0] pv_last_b, pv_prev_b;
   logic [2:0]  pv_last_op, pv_prev_op;
   logic [2:0]  pv_last_err, pv_prev_err;

   alu_serial_rx_if bus ();

   alu_serial_rx dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.pkt_valid === 1'b1) begin
         pv_cnt      = pv_cnt + 1;
         pv_prev_cyc = pv_last_cyc;
         pv_prev_a   = pv_last_a;
         pv_prev_b   = pv_last_b;
         pv_prev_op  = pv_last_op;
         pv_prev_err = pv_last_err;
         pv_last_cyc = cyc;
         pv_last_a   = bus.a_out;
         pv_last_b   = bus.b_out;
         pv_last_op  = bus.op_out;
         pv_last_err = {bus.err_data, bus.err_crc, bus.err_op};
      end
      if (bus.err_frame === 1'b1) ef_cnt = ef_cnt + 1;
   end

   function automatic logic [3:0] crc4(input logic [31:0] b,
                                        input logic [31:0] a,
                                        input logic [2:0]  op);
      logic [67:0] v;
      logic [3:0]  c;
      logic        fb;
      v = {b, a, 1'b1, op};
      c = 4'd0;
      for (int i = 67; i >= 0; i--) begin
         fb = c[3] ^ v[i];
         c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
      end
      return c;
   endfunction

   task automatic send_bit(input logic b);
      @(negedge clk);
      bus.sin = b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   task automatic send_frame(input logic t, input logic [7:0] p,
                             input logic stop);
      send_bit(1'b0);
      send_bit(t);
      for (int i = 7; i >= 0; i--) send_bit(p[i]);
      send_bit(stop);
   endtask

   // returns right after the CMD stop bit is driven
   task automatic send_pkt(input logic [31:0] b, input logic [31:0] a,
                           input logic [2:0] op, input logic [3:0] crc,
                           input int nd, input int gap);
      logic [63:0] v;
      logic [7:0]  by;
      v = {b, a};
      for (int i = 0; i < nd; i++) begin
         by = (i < 8) ? v[63-8*i -: 8] : 8'h00;
         send_frame(1'b0, by, 1'b1);
         idle(gap);
      end
      send_frame(1'b1, {1'b0, op, crc}, 1'b1);
   endtask

   task automatic test_reset();
      bus.sin = 1'b1;
      rst_n   = 1'b0;
      repeat (3) @(negedge clk);
      vecs++;
      if ({bus.pkt_valid, bus.err_data, bus.err_crc, bus.err_op,
           bus.err_frame, bus.busy} !== 6'b0) begin
         errs++;
         $display("FAIL reset_flags got %b exp 000000",
                  {bus.pkt_valid, bus.err_data, bus.err_crc, bus.err_op,
                   bus.err_frame, bus.busy});
      end
      vecs++;
      if ({bus.a_out, bus.b_out, bus.op_out} !== 67'd0) begin
         errs++;
         $display("FAIL reset_outs got a=%h b=%h op=%b exp 0",
                  bus.a_out, bus.b_out, bus.op_out);
      end
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_good();
      int n0;
      n0 = pv_cnt;
      send_pkt(32'd2, 32'd1, 3'b100, 4'hC, 8, 1);
      vecs++;
      if (bus.busy !== 1'b1) begin
         errs++;
         $display("FAIL good_busy got %b exp 1", bus.busy);
      end
      @(negedge clk);
      bus.sin = 1'b1;
      vecs++;
      if (bus.pkt_valid !== 1'b1) begin
         errs++;
         $display("FAIL good_pv got %b exp 1", bus.pkt_valid);
      end
      vecs++;
      if ({bus.err_data, bus.err_crc, bus.err_op, bus.busy} !== 4'b0) begin
         errs++;
         $display("FAIL good_err got %b exp 0000",
                  {bus.err_data, bus.err_crc, bus.err_op, bus.busy});
      end
      vecs++;
      if (bus.a_out !== 32'd1 || bus.b_out !== 32'd2 ||
          bus.op_out !== 3'b100) begin
         errs++;
         $display("FAIL good_outs got a=%h b=%h op=%b exp a=1 b=2 op=100",
                  bus.a_out, bus.b_out, bus.op_out);
      end
      @(negedge clk);
      vecs++;
      if (bus.pkt_valid !== 1'b0) begin
         errs++;
         $display("FAIL good_pulse got %b exp 0", bus.pkt_valid);
      end
      idle(2);
      vecs++;
      if (pv_cnt - n0 !== 1) begin
         errs++;
         $display("FAIL good_count got %0d exp 1", pv_cnt - n0);
      end
   endtask

   task automatic test_crc_err();
      send_pkt(32'd2, 32'd1, 3'b100, 4'hD, 8, 1);
      @(negedge clk);
      bus.sin = 1'b1;
      vecs++;
      if ({bus.pkt_valid, bus.err_data, bus.err_crc, bus.err_op}
          !== 4'b1010) begin
         errs++;
         $display("FAIL crc_err got %b exp 1010",
                  {bus.pkt_valid, bus.err_data, bus.err_crc, bus.err_op});
      end
      vecs++;
      if (bus.a_out !== 32'd1 || bus.b_out !== 32'd2 ||
          bus.op_out !== 3'b100) begin
         errs++;
         $display("FAIL crc_hold got a=%h b=%h op=%b exp a=1 b=2 op=100",
                  bus.a_out, bus.b_out, bus.op_out);
      end
      idle(2);
   endtask

   task automatic test_op_err();
      send_pkt(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010,
               crc4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010), 8, 1);
      @(negedge clk);
      bus.sin = 1'b1;
      vecs++;
      if ({bus.pkt_valid, bus.err_data, bus.err_crc, bus.err_op}
          !== 4'b1001) begin
         errs++;
         $display("FAIL op_err got %b exp 1001",
                  {bus.pkt_valid, bus.err_data, bus.err_crc, bus.err_op});
      end
      vecs++;
      if (bus.a_out !== 32'd1 || bus.b_out !== 32'd2 ||
          bus.op_out !== 3'b100) begin
         errs++;
         $display("FAIL op_hold got a=%h b=%h op=%b exp a=1 b=2 op=100",
                  bus.a_out, bus.b_out, bus.op_out);
      end
      idle(2);
   endtask

   task automatic test_data_count();
      int nd [2] = '{7, 9};
      foreach (nd[k]) begin
         send_pkt(32'd2, 32'd1, 3'b100, 4'hC, nd[k], 1);
         @(negedge clk);
         bus.sin = 1'b1;
         vecs++;
         if ({bus.pkt_valid, bus.err_data, bus.err_crc, bus.err_op}
             !== 4'b1100) begin
            errs++;
            $display("FAIL data_cnt_%0d got %b exp 1100", nd[k],
                     {bus.pkt_valid, bus.err_data, bus.err_crc, bus.err_op});
         end
         idle(2);
      end
   endtask

   task automatic test_frame_err();
      int          n0;
      logic [31:0] b, a;
      n0 = pv_cnt;
      send_frame(1'b0, 8'h11, 1'b1);
      idle(1);
      send_frame(1'b0, 8'h22, 1'b1);
      idle(1);
      send_frame(1'b0, 8'h33, 1'b0);
      @(negedge clk);
      bus.sin = 1'b1;
      vecs++;
      if ({bus.err_frame, bus.pkt_valid, bus.busy} !== 3'b100) begin
         errs++;
         $display("FAIL frame_err got %b exp 100",
                  {bus.err_frame, bus.pkt_valid, bus.busy});
      end
      @(negedge clk);
      vecs++;
      if (bus.err_frame !== 1'b0) begin
         errs++;
         $display("FAIL frame_pulse got %b exp 0", bus.err_frame);
      end
      idle(2);
      b = 32'hA5A5_0001;
      a = 32'h0000_00FF;
      send_pkt(b, a, 3'b000, crc4(b, a, 3'b000), 8, 1);
      @(negedge clk);
      bus.sin = 1'b1;
      vecs++;
      if ({bus.pkt_valid, bus.err_data, bus.err_crc, bus.err_op}
          !== 4'b1000) begin
         errs++;
         $display("FAIL frame_next got %b exp 1000",
                  {bus.pkt_valid, bus.err_data, bus.err_crc, bus.err_op});
      end
      vecs++;
      if (bus.a_out !== a || bus.b_out !== b || bus.op_out !== 3'b000) begin
         errs++;
         $display("FAIL frame_outs got a=%h b=%h op=%b exp a=%h b=%h op=000",
                  bus.a_out, bus.b_out, bus.op_out, a, b);
      end
      idle(2);
      vecs++;
      if (pv_cnt - n0 !== 1) begin
         errs++;
         $display("FAIL frame_pvcount got %0d exp 1", pv_cnt - n0);
      end
   endtask

   task automatic test_reset_mid();
      int          n0, e0;
      logic [31:0] b, a;
      b = 32'h1234_5678;
      a = 32'h9ABC_DEF0;
      for (int i = 0; i < 4; i++) begin
         send_frame(1'b0, 8'h5A, 1'b1);
         idle(1);
      end
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      n0 = pv_cnt;
      e0 = ef_cnt;
      idle(3);
      vecs++;
      if (pv_cnt != n0 || ef_cnt != e0 || bus.busy !== 1'b0) begin
         errs++;
         $display("FAIL rst_mid_quiet got pv=%0d ef=%0d busy=%b exp 0 0 0",
                  pv_cnt - n0, ef_cnt - e0, bus.busy);
      end
      send_pkt(b, a, 3'b001, crc4(b, a, 3'b001), 8, 1);
      @(negedge clk);
      bus.sin = 1'b1;
      vecs++;
      if ({bus.pkt_valid, bus.err_data, bus.err_crc, bus.err_op}
          !== 4'b1000) begin
         errs++;
         $display("FAIL rst_mid_pv got %b exp 1000",
                  {bus.pkt_valid, bus.err_data, bus.err_crc, bus.err_op});
      end
      vecs++;
      if (bus.a_out !== a || bus.b_out !== b || bus.op_out !== 3'b001) begin
         errs++;
         $display("FAIL rst_mid_outs got a=%h b=%h op=%b exp a=%h b=%h op=001",
                  bus.a_out, bus.b_out, bus.op_out, a, b);
      end
      idle(2);
      vecs++;
      if (pv_cnt - n0 !== 1) begin
         errs++;
         $display("FAIL rst_mid_count got %0d exp 1", pv_cnt - n0);
      end
   endtask

   task automatic test_back_to_back();
      int          n0;
      logic [31:0] b1, a1, b2, a2;
      b1 = 32'hDEAD_BEEF;
      a1 = 32'h0BAD_F00D;
      b2 = 32'h0000_0003;
      a2 = 32'h8000_0000;
      n0 = pv_cnt;
      send_pkt(b1, a1, 3'b101, crc4(b1, a1, 3'b101), 8, 0);
      send_pkt(b2, a2, 3'b000, crc4(b2, a2, 3'b000), 8, 0);
      idle(4);
      vecs++;
      if (pv_cnt - n0 !== 2) begin
         errs++;
         $display("FAIL b2b_count got %0d exp 2", pv_cnt - n0);
      end
      vecs++;
      if (pv_last_cyc - pv_prev_cyc !== 99) begin
         errs++;
         $display("FAIL b2b_spacing got %0d exp 99",
                  pv_last_cyc - pv_prev_cyc);
      end
      vecs++;
      if (pv_prev_a !== a1 || pv_prev_b !== b1 || pv_prev_op !== 3'b101 ||
          pv_prev_err !== 3'b000) begin
         errs++;
         $display("FAIL b2b_first got a=%h b=%h op=%b e=%b exp a=%h b=%h op=101 e=000",
                  pv_prev_a, pv_prev_b, pv_prev_op, pv_prev_err, a1, b1);
      end
      vecs++;
      if (pv_last_a !== a2 || pv_last_b !== b2 || pv_last_op !== 3'b000 ||
          pv_last_err !== 3'b000) begin
         errs++;
         $display("FAIL b2b_second got a=%h b=%h op=%b e=%b exp a=%h b=%h op=000 e=000",
                  pv_last_a, pv_last_b, pv_last_op, pv_last_err, a2, b2);
      end
   endtask

   initial begin
      bus.sin = 1'b1;
      test_reset();
      test_good();
      test_crc_err();
      test_op_err();
      test_data_count();
      test_frame_err();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
